// File: rtl/seven_seg_pkg.sv
// ============================================================================
// seven_seg_pkg : shared constants and digit-select decode for seven_seg_capture
// Rev 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns; element d is the pattern shown for decimal digit d.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } sel_dec_t;

  function automatic sel_dec_t sel_to_idx(input logic [7:0] sel);
    sel_dec_t r;
    int       n;
    r = '0;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sel[i]) begin
        n     = n + 1;
        r.idx = 3'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_pattern_decode.sv
// ============================================================================
// seven_seg_pattern_decode : 7-bit active-low pattern -> BCD value + error flag
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       err
);

  always_comb begin
    val = 4'hE;
    err = 1'b1;
    if (pat == SEG_BLANK) begin
      val = 4'hF;
      err = 1'b0;
    end
    for (int d = 0; d < 10; d++) begin
      if (pat == SEG_DIGIT[d]) begin
        val = 4'(d);
        err = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_capture.sv
// ============================================================================
// seven_seg_capture : debounce, demultiplex and order-check a 7-seg scan bus,
// publishing a coherent 8-digit frame. Decode enabled by SEVEN_SEG_CAPTURE_DECODE_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CE,
  input  logic [6:0]  seg_in,
  input  logic [7:0]  sel_in,
  output logic [55:0] pat_flat,
  output logic [31:0] val_flat,
  output logic [7:0]  decode_err,
  output logic        frame_valid,
  output logic        sel_err,
  output logic        seq_err,
  output logic        stalled
);

  localparam logic [7:0]  STABLE_W  = 8'(STABLE_CNT);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [7:0]       prev_sel_q, prev_sel_d;
  logic [6:0]       prev_seg_q, prev_seg_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic [7:0][6:0]  shadow_q, shadow_d;
  logic [7:0]       seen_q, seen_d;
  logic [2:0]       exp_idx_q, exp_idx_d;
  logic             synced_q, synced_d;
  logic [55:0]      pat_q, pat_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             seq_err_q, seq_err_d;
  logic [15:0]      idle_q, idle_d;

  sel_dec_t   sel_dec;
  logic       accept;
  logic [7:0] seen_next;

  always_comb begin
    sel_dec       = sel_to_idx(sel_in);
    prev_sel_d    = prev_sel_q;
    prev_seg_d    = prev_seg_q;
    cnt_d         = cnt_q;
    lock_d        = lock_q;
    shadow_d      = shadow_q;
    seen_d        = seen_q;
    exp_idx_d     = exp_idx_q;
    synced_d      = synced_q;
    pat_d         = pat_q;
    frame_valid_d = 1'b0;
    sel_err_d     = 1'b0;
    seq_err_d     = 1'b0;
    idle_d        = idle_q;
    accept        = 1'b0;
    seen_next     = seen_q;

    if (CE) begin
      prev_sel_d = sel_in;
      prev_seg_d = seg_in;
      idle_d     = (idle_q >= TIMEOUT_W) ? idle_q : idle_q + 16'd1;
      if (!sel_dec.valid) begin
        sel_err_d = 1'b1;
        cnt_d     = 8'd0;
        lock_d    = 1'b0;
      end else begin
        if (sel_in == prev_sel_q && seg_in == prev_seg_q) begin
          cnt_d = (cnt_q >= STABLE_W) ? cnt_q : cnt_q + 8'd1;
        end else begin
          cnt_d  = 8'd1;
          lock_d = 1'b0;
        end
        accept = (cnt_d == STABLE_W) && !lock_d;
      end
    end

    if (accept) begin
      lock_d                = 1'b1;
      idle_d                = 16'd0;
      synced_d              = 1'b1;
      shadow_d[sel_dec.idx] = seg_in;
      // The very first acceptance after reset defines the frame start.
      if (!synced_q || sel_dec.idx == exp_idx_q) begin
        seen_next = seen_q | (8'b1 << sel_dec.idx);
      end else begin
        seq_err_d = 1'b1;
        seen_next = 8'b1 << sel_dec.idx;
      end
      exp_idx_d = sel_dec.idx + 3'd1;
      if (seen_next == 8'hFF) begin
        pat_d         = shadow_d;
        frame_valid_d = 1'b1;
        seen_next     = 8'h00;
      end
      seen_d = seen_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      prev_sel_q    <= 8'hFF;
      prev_seg_q    <= SEG_BLANK;
      cnt_q         <= 8'd0;
      lock_q        <= 1'b0;
      shadow_q      <= {NUM_DIGITS{SEG_BLANK}};
      seen_q        <= 8'h00;
      exp_idx_q     <= 3'd0;
      synced_q      <= 1'b0;
      pat_q         <= {NUM_DIGITS{SEG_BLANK}};
      frame_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      idle_q        <= 16'd0;
    end else begin
      prev_sel_q    <= prev_sel_d;
      prev_seg_q    <= prev_seg_d;
      cnt_q         <= cnt_d;
      lock_q        <= lock_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      exp_idx_q     <= exp_idx_d;
      synced_q      <= synced_d;
      pat_q         <= pat_d;
      frame_valid_q <= frame_valid_d;
      sel_err_q     <= sel_err_d;
      seq_err_q     <= seq_err_d;
      idle_q        <= idle_d;
    end
  end

  assign pat_flat    = pat_q;
  assign frame_valid = frame_valid_q;
  assign sel_err     = sel_err_q;
  assign seq_err     = seq_err_q;
  assign stalled     = (idle_q >= TIMEOUT_W);

`ifdef SEVEN_SEG_CAPTURE_DECODE_EN
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_decode
    seven_seg_pattern_decode u_decode (
      .pat (pat_q[7*k +: 7]),
      .val (val_flat[4*k +: 4]),
      .err (decode_err[k])
    );
  end
`else
  assign val_flat   = 32'hFFFF_FFFF;
  assign decode_err = 8'h00;
`endif

endmodule

`default_nettype wire
